// File: rtl/i2c_slave_ctrl_mp_if.sv
// rtl/i2c_slave_ctrl_mp_if.sv - bus-condition, shift-register and FIFO handshake bundle for i2c_slave_ctrl_mp
interface i2c_slave_ctrl_mp_if #(
  parameter int NUM_ADDR = 2,
  parameter int BCNT_W   = 8
);
  logic                   start;
  logic                   stop;
  logic                   ack_prep;
  logic                   ack_check;
  logic                   ack_done;
  logic                   SDA_sync;
  logic [7:0]             rx_byte;
  logic [10*NUM_ADDR-1:0] own_addr;
  logic [NUM_ADDR-1:0]    addr_en;
  logic [NUM_ADDR-1:0]    addr_10b;
  logic                   en_clock_stretch;
  logic                   TX_fifo_empty;
  logic                   RX_fifo_almost_full;
  logic                   rx_enable;
  logic                   tx_enable;
  logic                   load_data;
  logic [1:0]             sda_mode;
  logic                   SCL_out_slave;
  logic                   busy_slave;
  logic                   TX_read_enable_slave;
  logic                   RX_write_enable_slave;
  logic                   ack_error_set_slave;
  logic                   stretch_timeout;
  logic [2:0]             matched_idx;
  logic [BCNT_W-1:0]      byte_count;
  logic                   gc_hit;

  modport master (
    output start, stop, ack_prep, ack_check, ack_done, SDA_sync, rx_byte,
           own_addr, addr_en, addr_10b, en_clock_stretch, TX_fifo_empty, RX_fifo_almost_full,
    input  rx_enable, tx_enable, load_data, sda_mode, SCL_out_slave, busy_slave,
           TX_read_enable_slave, RX_write_enable_slave, ack_error_set_slave,
           stretch_timeout, matched_idx, byte_count, gc_hit
  );

  modport slave (
    input  start, stop, ack_prep, ack_check, ack_done, SDA_sync, rx_byte,
           own_addr, addr_en, addr_10b, en_clock_stretch, TX_fifo_empty, RX_fifo_almost_full,
    output rx_enable, tx_enable, load_data, sda_mode, SCL_out_slave, busy_slave,
           TX_read_enable_slave, RX_write_enable_slave, ack_error_set_slave,
           stretch_timeout, matched_idx, byte_count, gc_hit
  );
endinterface

// File: rtl/i2c_slave_ctrl_mp.sv
// rtl/i2c_slave_ctrl_mp.sv - multi-address I2C slave main FSM; define GENERAL_CALL_EN to accept general call 0x00
module i2c_slave_ctrl_mp #(
  parameter int NUM_ADDR  = 2,
  parameter int STRETCH_W = 12,
  parameter int BCNT_W    = 8
) (
  input logic                clk,
  input logic                n_rst,
  i2c_slave_ctrl_mp_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE, GET_A1, CHK_A1, NO_MATCH, ACK_A1, GET_A2, CHK_A2, ACK_A, TX_WAIT, TX_LOAD,
    TX_SHIFT, TX_ACKW, TX_ACKC, TX_POP, RX_WAIT, RX_SHIFT, RX_ACK, RX_NACK, RX_COMMIT
  } state_t;

  localparam logic [STRETCH_W-1:0] ST_MAX   = '1;
  localparam logic [BCNT_W-1:0]    BC_MAX   = '1;
  localparam logic [1:0]           SDA_REL  = 2'b00;
  localparam logic [1:0]           SDA_ACK  = 2'b01;
  localparam logic [1:0]           SDA_NACK = 2'b10;
  localparam logic [1:0]           SDA_TX   = 2'b11;

  state_t                state, state_prev, next_state;
  logic                  rw_q, ack_bit_q, rx_nack_q;
  logic [NUM_ADDR-1:0]   hit10_q, hit7, hit10a, hit10b;
  logic [STRETCH_W-1:0]  st_cnt;
  logic [BCNT_W-1:0]     bcnt;
  logic [2:0]            idx_q;
  logic                  gc_match;
  logic                  entry, ovr, stretching;
  logic                  rx_en_d, tx_en_d, load_d, scl_d, busy_d;
  logic                  tx_rd_d, rx_wr_d, ack_err_d, timeout_d;
  logic [1:0]            sda_d;

  function automatic logic [2:0] first_idx(input logic [NUM_ADDR-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // first cycle in a state: FIFO pulses and byte counting fire only here
  assign entry = (state != state_prev);

  // per-slot address compare; 0x00 is reserved and never hits a 7-bit slot
  always_comb begin
    hit7   = '0;
    hit10a = '0;
    hit10b = '0;
    for (int i = 0; i < NUM_ADDR; i++) begin
      hit7[i]   = bus.addr_en[i] & ~bus.addr_10b[i] & (bus.rx_byte[7:1] != 7'd0)
                & (bus.rx_byte[7:1] == bus.own_addr[10*i +: 7]);
      hit10a[i] = bus.addr_en[i] & bus.addr_10b[i]
                & (bus.rx_byte[7:1] == {5'b11110, bus.own_addr[10*i+8 +: 2]});
      hit10b[i] = hit10_q[i] & (bus.rx_byte == bus.own_addr[10*i +: 8]);
    end
  end

`ifdef GENERAL_CALL_EN
  logic gc_q;
  assign gc_match = (bus.rx_byte == 8'h00);

  // general-call flag: set on a 0x00 address hit, dropped at the next start or back in IDLE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                            gc_q <= 1'b0;
    else if (bus.start || state == IDLE)   gc_q <= 1'b0;
    else if (state == CHK_A1 && gc_match)  gc_q <= 1'b1;
  end
  assign bus.gc_hit = gc_q;
`else
  assign gc_match   = 1'b0;
  assign bus.gc_hit = 1'b0;
`endif

  // state register plus the previous state for entry detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      state_prev <= IDLE;
    end else begin
      state      <= next_state;
      state_prev <= state;
    end
  end

  // next state and the output decode that gets registered one clock later
  always_comb begin
    next_state = state;
    stretching = 1'b0;
    rx_en_d    = 1'b0;
    tx_en_d    = 1'b0;
    load_d     = 1'b0;
    busy_d     = (state != IDLE);
    sda_d      = SDA_REL;
    tx_rd_d    = 1'b0;
    rx_wr_d    = 1'b0;
    ack_err_d  = 1'b0;
    ovr        = bus.start | (bus.stop & (state != IDLE));
    case (state)
      IDLE: ;
      GET_A1: begin
        rx_en_d = 1'b1;
        if (bus.ack_prep) next_state = CHK_A1;
      end
      CHK_A1: begin
        if (|hit7 || gc_match) next_state = ACK_A;
        else if (|hit10a)      next_state = ACK_A1;
        else                   next_state = NO_MATCH;
      end
      NO_MATCH: begin
        sda_d = SDA_NACK;
        if (bus.ack_done) next_state = IDLE;
      end
      ACK_A1: begin
        sda_d = SDA_ACK;
        if (bus.ack_done) next_state = GET_A2;
      end
      GET_A2: begin
        rx_en_d = 1'b1;
        if (bus.ack_prep) next_state = CHK_A2;
      end
      CHK_A2: next_state = (|hit10b) ? ACK_A : NO_MATCH;
      ACK_A: begin
        sda_d = SDA_ACK;
        if (bus.ack_done) next_state = rw_q ? TX_WAIT : RX_WAIT;
      end
      TX_WAIT: begin
        if (!bus.TX_fifo_empty) next_state = TX_LOAD;
        else if (bus.en_clock_stretch) begin
          stretching = 1'b1;
          if (st_cnt == ST_MAX) next_state = IDLE;
        end
      end
      TX_LOAD: begin
        load_d     = 1'b1;
        sda_d      = SDA_ACK;
        next_state = TX_SHIFT;
      end
      TX_SHIFT: begin
        sda_d   = SDA_TX;
        tx_en_d = 1'b1;
        if (bus.ack_prep) next_state = TX_ACKW;
      end
      TX_ACKW: if (bus.ack_check) next_state = TX_ACKC;
      TX_ACKC: begin
        ack_err_d  = ack_bit_q;
        next_state = ack_bit_q ? IDLE : TX_POP;
      end
      TX_POP: begin
        tx_rd_d = entry;
        if (bus.ack_done) next_state = TX_WAIT;
      end
      RX_WAIT: begin
        if (bus.RX_fifo_almost_full && bus.en_clock_stretch) begin
          stretching = 1'b1;
          if (st_cnt == ST_MAX) next_state = IDLE;
        end else next_state = RX_SHIFT;
      end
      RX_SHIFT: begin
        rx_en_d = 1'b1;
        if (bus.ack_prep) next_state = bus.RX_fifo_almost_full ? RX_NACK : RX_ACK;
      end
      RX_ACK: begin
        sda_d      = SDA_ACK;
        next_state = RX_COMMIT;
      end
      RX_NACK: begin
        sda_d      = SDA_NACK;
        next_state = RX_COMMIT;
      end
      RX_COMMIT: begin
        sda_d   = rx_nack_q ? SDA_NACK : SDA_ACK;
        rx_wr_d = entry & ~rx_nack_q;
        if (bus.ack_done) next_state = RX_WAIT;
      end
      default: next_state = IDLE;
    endcase
    scl_d     = stretching & (st_cnt != ST_MAX);
    timeout_d = stretching & (st_cnt == ST_MAX);
    // a bus condition aborts the current step: SCL is released and no pulse goes out
    if (ovr) begin
      scl_d     = 1'b0;
      timeout_d = 1'b0;
      tx_rd_d   = 1'b0;
      rx_wr_d   = 1'b0;
      ack_err_d = 1'b0;
    end
    if (bus.start)     next_state = GET_A1;
    else if (ovr)      next_state = IDLE;
  end

  // transaction context: direction, master ACK bit, NACK path, 10-bit candidates, stretch timer
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rw_q      <= 1'b0;
      ack_bit_q <= 1'b0;
      rx_nack_q <= 1'b0;
      hit10_q   <= '0;
      st_cnt    <= '0;
    end else begin
      if (state == GET_A1)                  rw_q      <= bus.rx_byte[0];
      if (state == TX_ACKW && bus.ack_check) ack_bit_q <= bus.SDA_sync;
      if (state == RX_SHIFT)                rx_nack_q <= bus.RX_fifo_almost_full;
      if (state == CHK_A1)                  hit10_q   <= hit10a;
      if (stretching && !ovr && st_cnt != ST_MAX) st_cnt <= st_cnt + 1'b1;
      else                                        st_cnt <= '0;
    end
  end

  // matched slot and saturating count of ACKed data bytes, both restarted by start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q <= 3'd0;
      bcnt  <= '0;
    end else begin
      if (bus.start)                           idx_q <= 3'd0;
      else if (state == CHK_A1 && |hit7)       idx_q <= first_idx(hit7);
      else if (state == CHK_A1 && gc_match)    idx_q <= 3'(NUM_ADDR);
      else if (state == CHK_A2 && |hit10b)     idx_q <= first_idx(hit10b);
      if (bus.start || state == ACK_A)                    bcnt <= '0;
      else if ((tx_rd_d || rx_wr_d) && bcnt != BC_MAX)    bcnt <= bcnt + 1'b1;
    end
  end

  assign bus.matched_idx = idx_q;
  assign bus.byte_count  = bcnt;

  // registered outputs, one clock behind the state they decode
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.rx_enable             <= 1'b0;
      bus.tx_enable             <= 1'b0;
      bus.load_data             <= 1'b0;
      bus.sda_mode              <= SDA_REL;
      bus.SCL_out_slave         <= 1'b0;
      bus.busy_slave            <= 1'b0;
      bus.TX_read_enable_slave  <= 1'b0;
      bus.RX_write_enable_slave <= 1'b0;
      bus.ack_error_set_slave   <= 1'b0;
      bus.stretch_timeout       <= 1'b0;
    end else begin
      bus.rx_enable             <= rx_en_d;
      bus.tx_enable             <= tx_en_d;
      bus.load_data             <= load_d;
      bus.sda_mode              <= sda_d;
      bus.SCL_out_slave         <= scl_d;
      bus.busy_slave            <= busy_d;
      bus.TX_read_enable_slave  <= tx_rd_d;
      bus.RX_write_enable_slave <= rx_wr_d;
      bus.ack_error_set_slave   <= ack_err_d;
      bus.stretch_timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl_mp.sv
// tb/tb_i2c_slave_ctrl_mp.sv - directed self-checking bench for i2c_slave_ctrl_mp
module tb_i2c_slave_ctrl_mp;

  localparam int P_START = 0;
  localparam int P_STOP  = 1;
  localparam int P_PREP  = 2;
  localparam int P_CHECK = 3;
  localparam int P_DONE  = 4;

  logic clk;
  logic n_rst;
  int   n_pass, n_tot, n_fail;
  int   rx_wr_cnt, tx_rd_cnt, ack_err_cnt, tmo_cnt;
  int   base_rx, base_tx, base_err, base_tmo;
  int   scl_n;
  logic seen;

  i2c_slave_ctrl_mp_if #(.NUM_ADDR(2), .BCNT_W(8)) bus ();

  i2c_slave_ctrl_mp #(.NUM_ADDR(2), .STRETCH_W(4), .BCNT_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.RX_write_enable_slave === 1'b1) rx_wr_cnt   <= rx_wr_cnt + 1;
    if (bus.TX_read_enable_slave === 1'b1)  tx_rd_cnt   <= tx_rd_cnt + 1;
    if (bus.ack_error_set_slave === 1'b1)   ack_err_cnt <= ack_err_cnt + 1;
    if (bus.stretch_timeout === 1'b1)       tmo_cnt     <= tmo_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int k);
    case (k)
      P_START: bus.start     = 1'b1;
      P_STOP:  bus.stop      = 1'b1;
      P_PREP:  bus.ack_prep  = 1'b1;
      P_CHECK: bus.ack_check = 1'b1;
      default: bus.ack_done  = 1'b1;
    endcase
    step(1);
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.ack_prep  = 1'b0;
    bus.ack_check = 1'b0;
    bus.ack_done  = 1'b0;
  endtask

  // start + first address byte; returns once the ACK/NACK decode is on the outputs
  task automatic addr_phase(input logic [7:0] b);
    pulse(P_START);
    step(1);
    bus.rx_byte = b;
    pulse(P_PREP);
    step(2);
  endtask

  // one write data byte, from RX_WAIT back to RX_WAIT
  task automatic rx_xfer(input logic [7:0] b);
    step(2);
    bus.rx_byte = b;
    pulse(P_PREP);
    step(3);
    pulse(P_DONE);
  endtask

  function automatic logic [11:0] ctl_outs();
    return {bus.rx_enable, bus.tx_enable, bus.load_data, bus.sda_mode, bus.SCL_out_slave,
            bus.busy_slave, bus.TX_read_enable_slave, bus.RX_write_enable_slave,
            bus.ack_error_set_slave, bus.stretch_timeout, bus.gc_hit};
  endfunction

  initial begin
    n_pass = 0; n_tot = 0; n_fail = 0;
    rx_wr_cnt = 0; tx_rd_cnt = 0; ack_err_cnt = 0; tmo_cnt = 0;
    n_rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.ack_prep = 1'b0; bus.ack_check = 1'b0;
    bus.ack_done = 1'b0; bus.SDA_sync = 1'b1; bus.rx_byte = 8'h00;
    bus.own_addr = {10'h03A, 10'h2C5};
    bus.addr_en = 2'b11; bus.addr_10b = 2'b01;
    bus.en_clock_stretch = 1'b0; bus.TX_fifo_empty = 1'b0; bus.RX_fifo_almost_full = 1'b0;
    step(3);
    chk("rst_outs", 32'(ctl_outs()), 32'h0);
    chk("rst_idx", 32'(bus.matched_idx), 32'd0);
    chk("rst_bcnt", 32'(bus.byte_count), 32'd0);
    n_rst = 1'b1;
    step(2);

    // 7-bit slot 1, three write bytes
    addr_phase(8'h74);
    chk("t1_ack_sda", 32'(bus.sda_mode), 32'd1);
    chk("t1_idx", 32'(bus.matched_idx), 32'd1);
    chk("t1_busy", 32'(bus.busy_slave), 32'd1);
    base_rx = rx_wr_cnt;
    pulse(P_DONE);
    for (int i = 0; i < 3; i++) rx_xfer(8'h10 + 8'(i));
    chk("t1_rx_wr", 32'(rx_wr_cnt - base_rx), 32'd3);
    chk("t1_bcnt", 32'(bus.byte_count), 32'd3);
    pulse(P_STOP);
    step(1);
    chk("t1_busy_after_stop", 32'(bus.busy_slave), 32'd0);

    // saturation of the byte counter
    addr_phase(8'h74);
    pulse(P_DONE);
    for (int i = 0; i < 257; i++) rx_xfer(8'(i));
    chk("sat_bcnt", 32'(bus.byte_count), 32'd255);
    pulse(P_STOP);
    step(1);

    // 10-bit slot 0, matching second byte
    addr_phase(8'hF5);
    chk("t2_ack_a1", 32'(bus.sda_mode), 32'd1);
    pulse(P_DONE);
    bus.rx_byte = 8'hC5;
    pulse(P_PREP);
    step(2);
    chk("t2_ack_a2", 32'(bus.sda_mode), 32'd1);
    chk("t2_idx", 32'(bus.matched_idx), 32'd0);
    pulse(P_STOP);
    step(1);

    // 10-bit, mismatching second byte
    addr_phase(8'hF5);
    pulse(P_DONE);
    bus.rx_byte = 8'hC4;
    pulse(P_PREP);
    step(2);
    chk("t2_nomatch_sda", 32'(bus.sda_mode), 32'd2);
    pulse(P_DONE);
    step(1);
    chk("t2_idle_busy", 32'(bus.busy_slave), 32'd0);

    // read with empty TX FIFO and stretching: 15 clocks of SCL hold, then timeout
    bus.TX_fifo_empty = 1'b1;
    bus.en_clock_stretch = 1'b1;
    base_tmo = tmo_cnt;
    addr_phase(8'h75);
    pulse(P_DONE);
    scl_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (bus.SCL_out_slave === 1'b1) scl_n++;
      if (bus.stretch_timeout === 1'b1) seen = 1'b1;
    end
    chk("t3_timeout_seen", 32'(seen), 32'd1);
    chk("t3_scl_clks", 32'(scl_n), 32'd15);
    step(2);
    chk("t3_busy", 32'(bus.busy_slave), 32'd0);
    chk("t3_scl_rel", 32'(bus.SCL_out_slave), 32'd0);
    chk("t3_tmo_pulses", 32'(tmo_cnt - base_tmo), 32'd1);
    bus.TX_fifo_empty = 1'b0;
    bus.en_clock_stretch = 1'b0;

    // read of two bytes: master ACK then NACK
    base_tx = tx_rd_cnt;
    base_err = ack_err_cnt;
    addr_phase(8'h75);
    pulse(P_DONE);
    step(2);
    chk("t4_load", 32'(bus.load_data), 32'd1);
    step(1);
    chk("t4_tx_sda", 32'(bus.sda_mode), 32'd3);
    chk("t4_tx_en", 32'(bus.tx_enable), 32'd1);
    pulse(P_PREP);
    step(1);
    bus.SDA_sync = 1'b0;
    pulse(P_CHECK);
    step(3);
    pulse(P_DONE);
    step(3);
    pulse(P_PREP);
    step(1);
    bus.SDA_sync = 1'b1;
    pulse(P_CHECK);
    step(3);
    chk("t4_tx_rd", 32'(tx_rd_cnt - base_tx), 32'd1);
    chk("t4_ack_err", 32'(ack_err_cnt - base_err), 32'd1);
    chk("t4_busy", 32'(bus.busy_slave), 32'd0);
    chk("t4_bcnt", 32'(bus.byte_count), 32'd1);

    // write into an almost-full RX FIFO: NACK, no write, then stop mid-byte
    base_rx = rx_wr_cnt;
    addr_phase(8'h74);
    bus.RX_fifo_almost_full = 1'b1;
    pulse(P_DONE);
    step(2);
    pulse(P_PREP);
    step(1);
    chk("t5_nack_sda", 32'(bus.sda_mode), 32'd2);
    step(2);
    pulse(P_DONE);
    step(2);
    chk("t5_rx_en", 32'(bus.rx_enable), 32'd1);
    pulse(P_STOP);
    step(1);
    chk("t5_outs_zero", 32'(ctl_outs()), 32'h0);
    chk("t5_no_rx_wr", 32'(rx_wr_cnt - base_rx), 32'd0);
    chk("t5_bcnt", 32'(bus.byte_count), 32'd0);

    // RX stretch, released by a repeated start
    bus.en_clock_stretch = 1'b1;
    addr_phase(8'h74);
    pulse(P_DONE);
    step(3);
    chk("rs_scl_hold", 32'(bus.SCL_out_slave), 32'd1);
    pulse(P_START);
    chk("rs_scl_rel", 32'(bus.SCL_out_slave), 32'd0);
    pulse(P_STOP);
    step(1);
    bus.en_clock_stretch = 1'b0;
    bus.RX_fifo_almost_full = 1'b0;

    // general call address
    addr_phase(8'h00);
`ifdef GENERAL_CALL_EN
    chk("t6_gc_sda", 32'(bus.sda_mode), 32'd1);
    chk("t6_gc_hit", 32'(bus.gc_hit), 32'd1);
    chk("t6_gc_idx", 32'(bus.matched_idx), 32'd2);
`else
    chk("t6_gc_sda", 32'(bus.sda_mode), 32'd2);
    chk("t6_gc_hit", 32'(bus.gc_hit), 32'd0);
`endif
    pulse(P_DONE);
    pulse(P_STOP);
    step(2);
    chk("end_idle", 32'(bus.busy_slave), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
